// File: rtl/fib_pkg.sv
// Shared widths and state encodings for the fibonacci request scheduler and generator.
package fib_pkg;
    localparam int FIB_WIDTH  = 14;
    localparam int ITER_WIDTH = 7;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} sched_state_t;
    typedef enum logic [1:0] {GEN_IDLE, GEN_RUN, GEN_DONE} gen_state_t;
endpackage

// File: rtl/fib_rr_picker.sv
// Combinational round-robin search: first asserted request at or above rr_ptr, wrapping.
module fib_rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any_valid,
    output logic [IDX_W-1:0] winner
);
    logic [IDX_W-1:0] cand [N_REQ];
    logic [N_REQ-1:0] hit;

    // cand[gi] is the requester visited at search offset gi from rr_ptr
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        logic [IDX_W:0] sum;
        assign sum       = (IDX_W+1)'(rr_ptr) + (IDX_W+1)'(gi);
        assign cand[gi]  = (sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum - (IDX_W+1)'(N_REQ))
                                                       : IDX_W'(sum);
        assign hit[gi]   = req[cand[gi]];
    end

    always_comb begin
        any_valid = |req;
        winner    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                winner = cand[i];
            end
        end
    end
endmodule

// File: rtl/fib_request_scheduler.sv
// Round-robin sharing of one fibonacci generator between N_REQ requesters, with a watchdog.
module fib_request_scheduler
    import fib_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ*ITER_WIDTH-1:0] req_iterations_i,
    output logic [N_REQ-1:0]            ack_o,
    output logic [FIB_WIDTH-1:0]        result_o,
    output logic                        overflow_o,
    output logic                        timeout_o,
    output logic                        busy_o,
    output logic                        gen_start_o,
    output logic [ITER_WIDTH-1:0]       gen_iterations_o,
    input  logic                        gen_ready_i,
    input  logic                        gen_done_i,
    input  logic                        gen_overflow_i,
    input  logic [FIB_WIDTH-1:0]        gen_fibonacci_i
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    sched_state_t           state_reg, state_next;
    logic [IDX_W-1:0]       rr_ptr_reg;
    logic [IDX_W-1:0]       grant_idx_reg;
    logic [ITER_WIDTH-1:0]  iter_reg;
    logic [TMR_W-1:0]       timer_reg;
    logic [FIB_WIDTH-1:0]   result_reg;
    logic                   overflow_reg;
    logic                   timeout_reg;

    logic                   any_valid;
    logic [IDX_W-1:0]       winner;
    logic [ITER_WIDTH-1:0]  iter_arr [N_REQ];
    logic                   grant;
    logic                   timer_expired;
    logic [IDX_W:0]         ptr_inc;
    logic [IDX_W-1:0]       ptr_next;

    fib_rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
        .req       (req_i),
        .rr_ptr    (rr_ptr_reg),
        .any_valid (any_valid),
        .winner    (winner)
    );

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign iter_arr[gi] = req_iterations_i[gi*ITER_WIDTH +: ITER_WIDTH];
        assign ack_o[gi]    = (state_reg == RESPOND) && (grant_idx_reg == IDX_W'(gi));
    end

    assign grant         = any_valid && gen_ready_i;
    assign timer_expired = (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));
    assign ptr_inc       = {1'b0, grant_idx_reg} + 1'b1;
    assign ptr_next      = (ptr_inc == (IDX_W+1)'(N_REQ)) ? '0 : ptr_inc[IDX_W-1:0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (gen_done_i || timer_expired) state_next = RESPOND;
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            grant_idx_reg <= '0;
            iter_reg      <= '0;
            timer_reg     <= '0;
            result_reg    <= '0;
            overflow_reg  <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        grant_idx_reg <= winner;
                        iter_reg      <= iter_arr[winner];
                    end
                end
                ISSUE: timer_reg <= '0;
                WAIT: begin
                    timer_reg <= timer_reg + 1'b1;
                    // a completion on the last allowed cycle still counts as a result
                    if (gen_done_i) begin
                        result_reg   <= gen_fibonacci_i;
                        overflow_reg <= gen_overflow_i;
                        timeout_reg  <= 1'b0;
                    end else if (timer_expired) begin
                        result_reg   <= '0;
                        overflow_reg <= 1'b0;
                        timeout_reg  <= 1'b1;
                    end
                end
                RESPOND: rr_ptr_reg <= ptr_next;
                default: ;
            endcase
        end
    end

    assign result_o         = result_reg;
    assign overflow_o       = overflow_reg;
    assign timeout_o        = timeout_reg;
    assign busy_o           = (state_reg != IDLE);
    assign gen_start_o      = (state_reg == ISSUE);
    assign gen_iterations_o = iter_reg;
endmodule

// File: tb/tb_fib_request_scheduler.sv
// Randomized scoreboard bench for fib_request_scheduler with a behavioural generator model.
module tb_fib_request_scheduler;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*7-1:0] req_iter = '0;
    logic [N-1:0]   ack_o;
    logic [13:0] result_o;
    logic        overflow_o, timeout_o, busy_o, gen_start_o;
    logic [6:0]  gen_iterations_o;
    logic        gen_ready, gen_done, gen_ov;
    logic [13:0] gen_fib;

    always #5 clk = ~clk;

    fib_request_scheduler #(.N_REQ(N), .TIMEOUT_CYCLES(255)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .req_i            (req),
        .req_iterations_i (req_iter),
        .ack_o            (ack_o),
        .result_o         (result_o),
        .overflow_o       (overflow_o),
        .timeout_o        (timeout_o),
        .busy_o           (busy_o),
        .gen_start_o      (gen_start_o),
        .gen_iterations_o (gen_iterations_o),
        .gen_ready_i      (gen_ready),
        .gen_done_i       (gen_done),
        .gen_overflow_i   (gen_ov),
        .gen_fibonacci_i  (gen_fib)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference fibonacci: values beyond 14 bits flag overflow and keep the last valid term.
    function automatic int fib_val(input int n);
        int a = 0, b = 1, t;
        for (int i = 0; i < n; i++) begin
            if (b > 16383) break;
            t = a + b; a = b; b = t;
        end
        return a;
    endfunction

    function automatic int fib_ovf(input int n);
        int a = 0, b = 1, t;
        for (int i = 0; i < n; i++) begin
            if (b > 16383) return 1;
            t = a + b; a = b; b = t;
        end
        return 0;
    endfunction

    // Generator model: random latency, optional hang mode and stray done pulses.
    bit hang_mode = 0, ready_force = 1, stray_en = 1, slow = 0;
    bit g_busy;
    int g_cnt;
    int g_iter;
    always @(posedge clk) begin
        if (reset_i) begin
            gen_ready <= 1'b1; gen_done <= 1'b0; gen_ov <= 1'b0; gen_fib <= '0;
            g_busy <= 0; g_cnt <= 0; g_iter <= 0;
        end else begin
            gen_done <= 1'b0;
            if (hang_mode) begin
                gen_ready <= ready_force;
                g_busy    <= 0;
            end else if (!g_busy) begin
                if (gen_start_o) begin
                    g_busy    <= 1;
                    gen_ready <= 1'b0;
                    g_iter    <= int'(gen_iterations_o);
                    g_cnt     <= int'($urandom_range(1, 6)) + (slow ? 200 : 0);
                end else begin
                    gen_ready <= 1'b1;
                    if (stray_en && $urandom_range(0, 15) == 0) begin
                        gen_done <= 1'b1;
                        gen_fib  <= 14'($urandom);
                        gen_ov   <= 1'($urandom);
                    end
                end
            end else if (g_cnt == 1) begin
                gen_done  <= 1'b1;
                gen_fib   <= 14'(fib_val(g_iter));
                gen_ov    <= 1'(fib_ovf(g_iter));
                gen_ready <= 1'b1;
                g_busy    <= 0;
            end else begin
                g_cnt <= g_cnt - 1;
            end
        end
    end

    typedef struct {int idx; int iter; int res; int ov; int to;} exp_t;
    exp_t sb[$];
    int need [N];
    int iters [N];
    int m_ptr = 0;

    // Round-robin prediction: every pending requester stays asserted until its services are done.
    task automatic plan();
        int n [N];
        int total = 0;
        exp_t e;
        for (int k = 0; k < N; k++) begin n[k] = need[k]; total += need[k]; end
        for (int s = 0; s < total; s++) begin
            for (int off = 0; off < N; off++) begin
                int k = (m_ptr + off) % N;
                if (n[k] > 0) begin
                    e.idx = k; e.iter = iters[k];
                    e.res = fib_val(iters[k]); e.ov = fib_ovf(iters[k]); e.to = 0;
                    sb.push_back(e);
                    n[k]--;
                    m_ptr = (k + 1) % N;
                    break;
                end
            end
        end
    endtask

    task automatic apply_req();
        for (int k = 0; k < N; k++) begin
            req[k] = (need[k] > 0);
            req_iter[k*7 +: 7] = 7'(iters[k]);
        end
    endtask

    function automatic bit any_need();
        for (int k = 0; k < N; k++) if (need[k] > 0) return 1;
        return 0;
    endfunction

    task automatic serve(input int budget);
        int cyc = 0;
        apply_req();
        while (any_need() && cyc < budget) begin
            @(negedge clk); cyc++;
            for (int k = 0; k < N; k++) if (ack_o[k] && need[k] > 0) need[k]--;
            apply_req();
        end
        if (any_need()) begin
            chk("serve_budget_expired", cyc, -1);
            for (int k = 0; k < N; k++) need[k] = 0;
            apply_req();
        end
    endtask

    task automatic wait_start(input string name, input int budget);
        int cyc = 0;
        while (!gen_start_o && cyc < budget) begin @(negedge clk); cyc++; end
        if (!gen_start_o) chk(name, cyc, -1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ack"}, int'(ack_o), 0);
        chk({tag, "_result"}, int'(result_o), 0);
        chk({tag, "_overflow"}, int'(overflow_o), 0);
        chk({tag, "_timeout"}, int'(timeout_o), 0);
        chk({tag, "_busy"}, int'(busy_o), 0);
        chk({tag, "_start"}, int'(gen_start_o), 0);
        chk({tag, "_iterations"}, int'(gen_iterations_o), 0);
    endtask

    // Monitor: compares every start and ack against the scoreboard head.
    bit prev_done = 0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_i) begin
            prev_done = 0;
        end else begin
            if (gen_start_o) begin
                if (sb.size() == 0) chk("spurious_start", 1, 0);
                else chk("start_iterations", int'(gen_iterations_o), sb[0].iter);
            end
            if (|ack_o) begin
                if (sb.size() == 0) begin
                    chk("spurious_ack", int'(ack_o), 0);
                end else begin
                    e = sb.pop_front();
                    $display("ack req=%0d iter=%0d result=%0d ovf=%0d to=%0d", e.idx, e.iter,
                             result_o, overflow_o, timeout_o);
                    chk("ack_onehot", int'(ack_o), 1 << e.idx);
                    chk("result", int'(result_o), e.res);
                    chk("overflow", int'(overflow_o), e.ov);
                    chk("timeout", int'(timeout_o), e.to);
                    if (!e.to) chk("ack_after_done", int'(prev_done), 1);
                end
            end
            prev_done = gen_done;
        end
    end

    initial begin
        int cyc, starts;
        exp_t e;
        for (int k = 0; k < N; k++) begin need[k] = 0; iters[k] = 0; end
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        reset_i = 1'b0;

        // fairness: all four asserted, requester 0 wants two services
        need = '{2, 1, 1, 1}; iters = '{5, 6, 7, 8};
        plan(); serve(500);

        need = '{1, 0, 0, 0}; iters[0] = 10; plan(); serve(200);
        need = '{0, 0, 1, 0}; iters[2] = 0;  plan(); serve(200);
        need = '{0, 0, 1, 0}; iters[2] = 1;  plan(); serve(200);
        need = '{0, 1, 0, 0}; iters[1] = 25; plan(); serve(200);

        for (int b = 0; b < 30; b++) begin
            for (int k = 0; k < N; k++) begin
                need[k]  = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 2));
                iters[k] = int'($urandom_range(0, 30));
            end
            plan(); serve(1000);
        end

        // requester drops its request once granted and must still be acked
        need = '{1, 0, 0, 0}; iters[0] = 20; plan(); apply_req();
        wait_start("drop_start_wait", 100);
        req[0] = 1'b0;
        cyc = 0;
        while (!ack_o[0] && cyc < 100) begin @(negedge clk); cyc++; end
        chk("ack_after_drop", int'(ack_o[0]), 1);
        need[0] = 0;
        @(negedge clk);

        // watchdog: generator never completes
        stray_en = 0; hang_mode = 1; ready_force = 1;
        need = '{0, 0, 0, 1}; iters[3] = 4; plan();
        sb[sb.size()-1].res = 0; sb[sb.size()-1].ov = 0; sb[sb.size()-1].to = 1;
        apply_req();
        wait_start("timeout_start_wait", 100);
        ready_force = 0;
        cyc = 0;
        while (!ack_o[3] && cyc < 400) begin @(negedge clk); cyc++; end
        chk("timeout_ack_latency", cyc, 256);
        need[3] = 0; apply_req();
        need[0] = 1; iters[0] = 9; apply_req();
        starts = 0;
        repeat (20) begin @(negedge clk); if (gen_start_o) starts++; end
        chk("no_grant_while_not_ready", starts, 0);
        plan();
        hang_mode = 0; stray_en = 1;
        serve(300);

        // reset during WAIT abandons the request; held requests regrant from pointer 0
        slow = 1;
        need = '{0, 1, 0, 1}; iters[1] = 12; iters[3] = 14; plan(); apply_req();
        wait_start("reset_start_wait", 100);
        repeat (5) @(negedge clk);
        reset_i = 1'b1;
        sb.delete();
        @(negedge clk);
        reset_i = 1'b0;
        chk_outputs_zero("mid_reset");
        m_ptr = 0;
        plan(); serve(1500);
        slow = 0;

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
